mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_3000: first byte address outside data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 req_op  input  3  operation: LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned for SH/SB.
REQ-009 req_pc  input  32  PC of the issuing instruction.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  pipeline consumes the response.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores.
REQ-013 resp_err  output  1  misaligned or out-of-range access.
REQ-014 dm_we  output  1  write strobe to data memory (MemWrite).
REQ-015 dm_addr  output  32  word address to data memory, bits [1:0] always 00.
REQ-016 dm_wdata  output  32  full word written to data memory.
REQ-017 dm_pc  output  32  PC forwarded to data memory for write logging.
REQ-018 dm_rdata  input  32  word read from data memory, combinational on dm_addr.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR, RSP.
REQ-020 Accept = req_valid && req_ready; op, addr, wdata and pc are latched on accept.
REQ-021 Misaligned (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0) or addr >= ADDR_LIMIT: IDLE->RSP with resp_err=1, dm_we never asserted.
REQ-022 Loads: IDLE->RD->RSP; in RD, dm_addr={addr[31:2],2'b00} and dm_rdata is captured at the edge leaving RD.
REQ-023 SW: IDLE->WR->RSP; in WR, dm_we=1 and dm_wdata=req_wdata.
REQ-024 SH/SB: IDLE->RD->WR->RSP read-modify-write; only the addressed lanes of the captured word are replaced.
REQ-025 Lanes are little-endian: byte k=addr[1:0] occupies bits [8k+7:8k]; halfword at addr[1] occupies bits [16*addr[1]+15:16*addr[1]].
REQ-026 LB/LH sign-extend, LBU/LHU zero-extend; LW returns the word unchanged.
REQ-027 dm_we SHALL be high for exactly one cycle per successful store, and never outside WR.
REQ-028 dm_addr, dm_wdata are 0 in IDLE and RSP; dm_pc holds the latched PC in RD/WR, else 0.
REQ-029 RSP holds resp_valid, resp_rdata, resp_err stable until resp_ready; on resp_ready, RSP->IDLE.
REQ-030 No new request is accepted in the cycle RSP completes; req_ready rises the next cycle.
REQ-031 Latency from accept to resp_valid: 2 cycles loads/SW, 3 cycles SH/SB, 1 cycle error.

Reset
REQ-032 While reset==0 at a rising edge: state=IDLE, all outputs 0, req_ready 0; req_ready=1 the first cycle after release.
REQ-033 Reset in any state, including WR, SHALL abort the operation; dm_we is forced 0 in any cycle where reset==0.

Structure
REQ-034 Package mau_pkg holds the op encoding (LW=0,LH=1,LHU=2,LB=3,LBU=4,SW=5,SH=6,SB=7), state enum and ADDR_LIMIT default.
REQ-035 One combinational sub-module lane_ext performs store-lane merge and load extension.

Verification
REQ-036 dm preloaded word0=32'h8899_AABB; LB addr 3 -> resp_rdata=32'hFFFF_FF88 at accept+2, err=0.
REQ-037 Same word; LHU addr 2 -> 32'h0000_8899; LH addr 0 -> 32'hFFFF_AABB.
REQ-038 SB addr 1, wdata 32'h0000_0012 -> one dm_we pulse, dm_addr 0, dm_wdata 32'h8899_12BB, resp at accept+3.
REQ-039 SW addr 2 -> resp_err=1 at accept+1, no dm_we; LW addr 32'h3000 -> resp_err=1.
REQ-040 resp_ready held low 5 cycles in RSP -> outputs stable, req_ready 0 throughout; then IDLE.
REQ-041 reset driven low during WR of SH -> dm_we 0 that cycle, memory unchanged, outputs 0, req_ready 1 after release.

Source files
------------

// File: rtl/mau_pkg.sv
// Package for the memory access unit.
// Holds the operation encoding, the FSM state type, the default data-memory
// limit and small decode helpers shared by the top and the lane sub-module.
package mau_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } mau_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } mau_state_e;

  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_3000;

  function automatic logic is_load(input mau_op_e op);
    return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
  endfunction

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
  function automatic logic is_misaligned(input mau_op_e op, input logic [1:0] offset);
    case (op)
      LW, SW:      return offset != 2'b00;
      LH, LHU, SH: return offset[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_ext.sv
// Byte-lane logic for the memory access unit (purely combinational).
// Ports:
//   op          operation (mau_op_e encoding)
//   offset      byte offset within the word (addr[1:0])
//   load_word   word read from data memory, used for load extension
//   old_word    previously captured word, used as the base of a store merge
//   store_data  right-aligned store data
//   load_data   sign/zero-extended load result
//   store_word  full word to write back (only addressed lanes replaced)
module lane_ext
  import mau_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] store_rep;
  logic [3:0]  byte_en;

  // Store data replicated across the word so each lane can pick its own slice.
  always_comb begin
    store_rep = store_data;
    case (mau_op_e'(op))
      SH:      store_rep = {2{store_data[15:0]}};
      SB:      store_rep = {4{store_data[7:0]}};
      default: store_rep = store_data;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign byte_en[gi] = (mau_op_e'(op) == SW)
                      || ((mau_op_e'(op) == SH) && (offset[1] == LANE[1]))
                      || ((mau_op_e'(op) == SB) && (offset == LANE));
    assign store_word[8*gi +: 8] = byte_en[gi] ? store_rep[8*gi +: 8] : old_word[8*gi +: 8];
  end

  always_comb begin
    byte_sel  = load_word[{offset, 3'b000} +: 8];
    half_sel  = load_word[{offset[1], 4'b0000} +: 16];
    load_data = '0;
    case (mau_op_e'(op))
      LW:      load_data = load_word;
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0000, half_sel};
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h000000, byte_sel};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a combinational-read data memory.
// Accepts one request at a time, checks alignment and range, performs the
// memory read and/or write (read-modify-write for SH/SB), then holds the
// response until the pipeline takes it.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op/addr/wdata/pc        request fields, latched on accept
//   resp_valid/resp_ready       response handshake
//   resp_rdata/resp_err         extended load data / error flag
//   dm_we/addr/wdata/pc         data memory write strobe, word address, data, PC
//   dm_rdata                    data memory read word (combinational on dm_addr)
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  mau_state_e  state_reg, state_next;
  mau_op_e     op_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] pc_reg;
  logic [31:0] word_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_err = is_misaligned(mau_op_e'(req_op), req_addr[1:0]) || (req_addr >= ADDR_LIMIT);

  // Loads extend the live memory word; stores merge into the word captured in RD.
  lane_ext u_lane_ext (
    .op         (op_reg),
    .offset     (addr_reg[1:0]),
    .load_word  (dm_rdata),
    .old_word   (word_reg),
    .store_data (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      op_reg    <= LW;
      addr_reg  <= '0;
      wdata_reg <= '0;
      pc_reg    <= '0;
      word_reg  <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg    <= mau_op_e'(req_op);
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            pc_reg    <= req_pc;
            err_reg   <= req_err;
            rdata_reg <= '0;
          end
        end
        RD: begin
          word_reg <= dm_rdata;
          if (is_load(op_reg)) begin
            rdata_reg <= load_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Every output is forced low while reset is asserted, which also kills a
  // write strobe mid-WR so an aborted store never reaches memory.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_pc      = '0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = RSP;
          end else if (mau_op_e'(req_op) == SW) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        state_next = ((op_reg == SH) || (op_reg == SB)) ? WR : RSP;
      end
      WR: begin
        state_next = RSP;
      end
      RSP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (reset) begin
      case (state_reg)
        IDLE: req_ready = 1'b1;
        RD: begin
          dm_addr = {addr_reg[31:2], 2'b00};
          dm_pc   = pc_reg;
        end
        WR: begin
          dm_we    = 1'b1;
          dm_addr  = {addr_reg[31:2], 2'b00};
          dm_wdata = store_word;
          dm_pc    = pc_reg;
        end
        RSP: begin
          resp_valid = 1'b1;
          resp_rdata = rdata_reg;
          resp_err   = err_reg;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
